// File: rtl/nor_gate_if.sv
// rtl/nor_gate_if.sv - operand/result bundle between a driver and the NOR gate block
interface nor_gate_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             clr_cnt;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] y_rise;
    logic [WIDTH-1:0] y_fall;
    logic [CNT_W-1:0] chg_cnt;

    modport master (
        output a, b, clr_cnt,
        input  y, y_q, y_rise, y_fall, chg_cnt
    );

    modport slave (
        input  a, b, clr_cnt,
        output y, y_q, y_rise, y_fall, chg_cnt
    );
endinterface

// File: rtl/nor_gate.sv
// rtl/nor_gate.sv - bitwise NOR with registered copy, edge pulses and change counter
module nor_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    nor_gate_if.slave  bus
);
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] yq_q;
    logic [WIDTH-1:0] yprev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign y_d = ~(bus.a | bus.b);

    // One count per edge no matter how many bits flip; clear beats increment.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.clr_cnt) begin
            cnt_d = '0;
        end else if ((y_d != yq_q) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            yq_q    <= '1;
            yprev_q <= '1;
            cnt_q   <= '0;
        end else begin
            yq_q    <= y_d;
            yprev_q <= yq_q;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.y       = y_d;
    assign bus.y_q     = yq_q;
    assign bus.y_rise  = yq_q & ~yprev_q;
    assign bus.y_fall  = ~yq_q & yprev_q;
    assign bus.chg_cnt = cnt_q;
endmodule

// File: tb/tb_nor_gate.sv
// tb/tb_nor_gate.sv - randomized model-checked bench for nor_gate (wide and saturating instances)
module tb_nor_gate;
    localparam int W   = 4;
    localparam int CW  = 4;
    localparam int W1  = 1;
    localparam int CW1 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    nor_gate_if #(.WIDTH(W),  .CNT_W(CW))  m_if();
    nor_gate_if #(.WIDTH(W1), .CNT_W(CW1)) s_if();

    nor_gate #(.WIDTH(W),  .CNT_W(CW))  u_dut (.clk(clk), .rst_n(rst_n), .bus(m_if));
    nor_gate #(.WIDTH(W1), .CNT_W(CW1)) u_sat (.clk(clk), .rst_n(rst_n), .bus(s_if));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Model: history of y as sampled at each rising edge, plus changes since last clear.
    logic [W-1:0]  m_hist [2];
    logic [W1-1:0] s_hist [2];
    int m_chg;
    int s_chg;
    bit m_ok = 1'b0;

    always @(posedge clk) begin
        logic [W-1:0]  my;
        logic [W1-1:0] sy;
        my = ~(m_if.a | m_if.b);
        sy = ~(s_if.a | s_if.b);
        if (!rst_n) begin
            m_hist[0] = '1; m_hist[1] = '1; m_chg = 0;
            s_hist[0] = '1; s_hist[1] = '1; s_chg = 0;
            m_ok = 1'b1;
        end else begin
            if (m_if.clr_cnt) m_chg = 0;
            else if (my != m_hist[0]) m_chg++;
            if (s_if.clr_cnt) s_chg = 0;
            else if (sy != s_hist[0]) s_chg++;
            m_hist[1] = m_hist[0]; m_hist[0] = my;
            s_hist[1] = s_hist[0]; s_hist[0] = sy;
        end
    end

    always @(negedge clk) begin
        logic [W-1:0]  ey, er, ef;
        logic [W1-1:0] sy, sr, sf;
        if (m_ok) begin
            ey = ~(m_if.a | m_if.b);
            er = m_hist[0] & ~m_hist[1];
            ef = ~m_hist[0] & m_hist[1];
            chk("m_y",      32'(m_if.y),       32'(ey));
            chk("m_y_q",    32'(m_if.y_q),     32'(m_hist[0]));
            chk("m_y_rise", 32'(m_if.y_rise),  32'(er));
            chk("m_y_fall", 32'(m_if.y_fall),  32'(ef));
            chk("m_cnt",    32'(m_if.chg_cnt), 32'(sat(m_chg, CW)));
            sy = ~(s_if.a | s_if.b);
            sr = s_hist[0] & ~s_hist[1];
            sf = ~s_hist[0] & s_hist[1];
            chk("s_y",      32'(s_if.y),       32'(sy));
            chk("s_y_q",    32'(s_if.y_q),     32'(s_hist[0]));
            chk("s_y_rise", 32'(s_if.y_rise),  32'(sr));
            chk("s_y_fall", 32'(s_if.y_fall),  32'(sf));
            chk("s_cnt",    32'(s_if.chg_cnt), 32'(sat(s_chg, CW1)));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0]    ga;
        logic [3:0][0:0] tt;
        tt = 4'b0001;
        m_if.a = '0; m_if.b = '0; m_if.clr_cnt = 1'b0;
        s_if.a = 1'b1; s_if.b = 1'b0; s_if.clr_cnt = 1'b0;
        rst_n = 1'b0;

        // Reset held two cycles with a=1 on the narrow instance.
        step();
        chk("lit_rst_y0", 32'(s_if.y), 32'h0);
        step();
        chk("lit_rst_y1", 32'(s_if.y), 32'h0);
        chk("lit_rst_myq", 32'(m_if.y_q), 32'hF);
        chk("lit_rst_mrise", 32'(m_if.y_rise), 32'h0);
        chk("lit_rst_mfall", 32'(m_if.y_fall), 32'h0);
        chk("lit_rst_mcnt", 32'(m_if.chg_cnt), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("lit_rel_syq", 32'(s_if.y_q), 32'h1);
        step();
        chk("lit_post_syq", 32'(s_if.y_q), 32'h0);
        chk("lit_post_sfall", 32'(s_if.y_fall), 32'h1);
        chk("lit_post_scnt", 32'(s_if.chg_cnt), 32'h1);
        chk("lit_post_mcnt", 32'(m_if.chg_cnt), 32'h0);
        chk("lit_post_mrise", 32'(m_if.y_rise), 32'h0);
        step();
        chk("lit_post_sfall_end", 32'(s_if.y_fall), 32'h0);

        // Combinational-only sequence, 10 ns apart.
        s_if.a = 1'b0; s_if.b = 1'b0; #1 chk("lit_c00", 32'(s_if.y), 32'h1);
        #9 s_if.a = 1'b1; #1 chk("lit_c10", 32'(s_if.y), 32'h0);
        #9 s_if.b = 1'b1; #1 chk("lit_c11", 32'(s_if.y), 32'h0);
        #9 s_if.a = 1'b0; #1 chk("lit_c01", 32'(s_if.y), 32'h0);

        // Truth-table sweep with one-cycle registered copy.
        for (int i = 0; i < 4; i++) begin
            {s_if.a, s_if.b} = 2'(i);
            #1 chk("lit_sweep_y", 32'(s_if.y), 32'(tt[i]));
            step();
            chk("lit_sweep_yq", 32'(s_if.y_q), 32'(tt[i]));
        end

        // Saturation of a 2-bit counter.
        s_if.clr_cnt = 1'b1; s_if.b = 1'b0;
        step();
        s_if.clr_cnt = 1'b0;
        chk("lit_sclr0", 32'(s_if.chg_cnt), 32'h0);
        for (int i = 0; i < 6; i++) begin
            s_if.a = ~s_if.a;
            step();
        end
        chk("lit_ssat", 32'(s_if.chg_cnt), 32'h3);
        step();
        chk("lit_ssat_hold", 32'(s_if.chg_cnt), 32'h3);
        s_if.clr_cnt = 1'b1;
        step();
        s_if.clr_cnt = 1'b0;
        chk("lit_sclr1", 32'(s_if.chg_cnt), 32'h0);

        // Wide instance: multi-bit change counts once, rise pulse on release.
        m_if.b = 4'b0101;
        #1 chk("lit_w_y_a", 32'(m_if.y), 32'hA);
        step();
        chk("lit_w_yq_a", 32'(m_if.y_q), 32'hA);
        chk("lit_w_fall", 32'(m_if.y_fall), 32'h5);
        chk("lit_w_cnt1", 32'(m_if.chg_cnt), 32'h1);
        m_if.b = 4'b0000;
        #1 chk("lit_w_y_f", 32'(m_if.y), 32'hF);
        step();
        chk("lit_w_rise", 32'(m_if.y_rise), 32'h5);
        chk("lit_w_cnt2", 32'(m_if.chg_cnt), 32'h2);
        step();
        chk("lit_w_rise_end", 32'(m_if.y_rise), 32'h0);
        chk("lit_w_cnt2_hold", 32'(m_if.chg_cnt), 32'h2);

        // Clear wins over a simultaneous change.
        m_if.clr_cnt = 1'b1; m_if.b = 4'b0011;
        step();
        m_if.clr_cnt = 1'b0;
        chk("lit_clr_win", 32'(m_if.chg_cnt), 32'h0);
        chk("lit_clr_yq", 32'(m_if.y_q), 32'hC);

        // Sub-cycle glitch between edges touches y only.
        #4 m_if.a = 4'hF;
        #1 chk("lit_glitch_y", 32'(m_if.y), 32'h0);
        #1 m_if.a = 4'h0;
        step();
        chk("lit_glitch_yq", 32'(m_if.y_q), 32'hC);
        chk("lit_glitch_cnt", 32'(m_if.chg_cnt), 32'h0);

        // Randomized traffic, clears, resets and glitches against the model.
        for (int i = 0; i < 400; i++) begin
            step();
            rst_n         = ($urandom_range(0, 63) != 0);
            m_if.a        = 4'($urandom);
            m_if.b        = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            m_if.clr_cnt  = ($urandom_range(0, 31) == 0);
            s_if.a        = 1'($urandom);
            s_if.b        = ($urandom_range(0, 2) == 0);
            s_if.clr_cnt  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) begin
                #4;
                ga = m_if.a;
                m_if.a = ~ga;
                #1 chk("rnd_glitch_y", 32'(m_if.y), 32'(4'(~(~ga | m_if.b))));
                #1 m_if.a = ga;
            end
        end
        rst_n = 1'b1;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/nor_gate.md
NOR_GATE -- requirements
Module: nor_gate

Interface
REQ-001 Parameter WIDTH, default 1, bit width of operands and NOR result.
REQ-002 Parameter CNT_W, default 16, width of the output-change counter.
REQ-003 Ports clk and rst_n: one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  single clock; all registers update on its rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 a  input  WIDTH  first operand.
REQ-007 b  input  WIDTH  second operand.
REQ-008 y  output  WIDTH  combinational bitwise NOR of a and b.
REQ-009 clr_cnt  input  1  synchronous clear of chg_cnt.
REQ-010 y_q  output  WIDTH  y registered one clock later.
REQ-011 y_rise  output  WIDTH  per-bit one-cycle pulse, y_q bit went 0->1.
REQ-012 y_fall  output  WIDTH  per-bit one-cycle pulse, y_q bit went 1->0.
REQ-013 chg_cnt  output  CNT_W  saturating count of clock edges where y_q changed.

Function
REQ-014 y SHALL equal ~(a | b) bitwise, zero clock latency, independent of clk and rst_n.
- Truth table per bit: 00->1, 01->0, 10->0, 11->0.
REQ-015 y SHALL settle in the same simulation time step as an input change, with no intermediate glitch value visible to the bench.
REQ-016 y_q SHALL load y on every rising clk while rst_n=1, giving 1-cycle latency.
REQ-017 Internal y_prev SHALL hold the previous y_q value.
- y_rise = y_q & ~y_prev; y_fall = ~y_q & y_prev; both registered-domain combinational decodes valid for exactly one cycle per change.
REQ-018 chg_cnt SHALL increment by 1 on each rising clk where y differs from y_q (in any bit).
- Saturates at all-ones; no wrap-around.
REQ-019 clr_cnt=1 SHALL force chg_cnt to 0 on the next rising clk.
- Takes priority over a simultaneous increment.
REQ-020 Multi-bit changes in one cycle SHALL count once, not once per bit.
REQ-021 Input changes shorter than one clock period that do not span a rising edge SHALL affect y only, not y_q, y_rise, y_fall or chg_cnt.

Reset
REQ-022 While rst_n=0 at a rising clk: y_q <= all ones, y_prev <= all ones, chg_cnt <= 0.
- y_rise=0 and y_fall=0 after reset.
REQ-023 Reset SHALL NOT affect y; y tracks a and b during reset.
REQ-024 Reset asserted mid-operation SHALL override clr_cnt and any pending increment on that edge.
REQ-025 First edge after reset release with a=b=0 SHALL produce no pulse and no count.

Verification
REQ-026 WIDTH=1, a=0, b=0 -> y=1; then a=1 after 10 ns -> y=0 in the same time step; then b=1 after 10 ns -> y=0; then a=0 after 10 ns -> y=0; all with no clock dependency.
REQ-027 Exhaustive sweep of all four a/b combinations -> y matches REQ-014 truth table and y_q matches y one clock later.
REQ-028 Reset held 2 cycles with a=1 -> y=0 throughout reset; after reset y_q=1 at release, then y_q=0 on next edge, y_fall pulses 1 cycle, chg_cnt=1.
REQ-029 CNT_W=2, toggle a every cycle for 6 cycles -> chg_cnt reaches 3 and holds 3; clr_cnt pulse -> chg_cnt=0 next cycle.
REQ-030 WIDTH=4, a=4'b0000, b=4'b0101 -> y=4'b1010.
- Then b=4'b0000 -> y=4'b1111, y_rise=4'b0101 for one cycle, chg_cnt +1.
REQ-031 Simultaneous clr_cnt=1 and output change on same edge -> chg_cnt=0, not 1.
